ex_mem_stage: RTL

// - EX->MEM pipeline stage directly downstream of the ALU: captures Y_out/Z/CY plus dest info per accepted instr.
// - Owns architectural flag register (p_Z, p_CY) fed back combinationally to the ALU carry/zero inputs.
// - 2-entry skid buffer so ex_ready is a pure register output; provides head-entry forwarding to operand muxes.

---
 rtl/ex_mem_stage_pkg.sv | 23 ++
 rtl/ex_flag_reg.sv | 27 ++
 rtl/ex_mem_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_pkg.sv
// Shared types and constants for the EX->MEM stage: default widths, buffer
// occupancy states, flag bit positions and the default-width payload record.
package ex_mem_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int RA_W_DEF   = 3;

    localparam int F_Z  = 0;
    localparam int F_CY = 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] result;
        logic [RA_W_DEF-1:0]   rd;
        logic                  rf_we;
    } ex_mem_entry_t;

endpackage

// File: rtl/ex_flag_reg.sv
// Architectural Z/CY flag register with an independent write enable per flag.
// Bit positions follow F_Z/F_CY from the package.
module ex_flag_reg
    import ex_mem_stage_pkg::*;
#(
    parameter logic [1:0] FLAG_RST = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] we,
    input  logic [1:0] d,
    output logic [1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= FLAG_RST;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (we[i]) begin
                    q[i] <= d[i];
                end
            end
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: 2-entry skid buffer with registered ex_ready, head
// forwarding to the operand muxes, and the architectural flag register.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int         DATA_W   = DATA_W_DEF,
    parameter int         RA_W     = RA_W_DEF,
    parameter logic [1:0] FLAG_RST = 2'b00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_z,
    input  logic              ex_cy,
    input  logic [1:0]        ex_flag_we,
    input  logic [RA_W-1:0]   ex_rd,
    input  logic              ex_rf_we,
    input  logic              flush,
    output logic              p_Z,
    output logic              p_CY,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_result,
    output logic [RA_W-1:0]   mem_rd,
    output logic              mem_rf_we,
    output logic              fwd_valid,
    output logic [RA_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_result
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [RA_W-1:0]   rd;
        logic              rf_we;
    } entry_t;

    stage_state_t state_q, state_d;
    entry_t       head_q, head_d;
    entry_t       skid_q, skid_d;
    entry_t       incoming;
    logic         ex_ready_q;
    logic         acc, deq;
    logic [1:0]   flag_we, flag_d, flag_q;

    always_comb begin
        incoming = '{result: ex_result, rd: ex_rd, rf_we: ex_rf_we};
        acc      = ex_valid & ex_ready_q & ~flush;
        deq      = (state_q != EMPTY) & mem_ready;
        state_d  = state_q;
        head_d   = head_q;
        skid_d   = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d = ONE;
                    head_d  = incoming;
                end
            end
            ONE: begin
                if (acc && deq) begin
                    head_d = incoming;
                end else if (acc) begin
                    state_d = FULL;
                    skid_d  = incoming;
                end else if (deq) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (deq) begin
                    state_d = ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A redirect discards everything held; the head may still drain this cycle.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            ex_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            ex_ready_q <= (state_d != FULL);
        end
    end

    // Flags commit at acceptance so the next EX instruction sees them without a bubble.
    always_comb begin
        flag_d       = '0;
        flag_d[F_Z]  = ex_z;
        flag_d[F_CY] = ex_cy;
        flag_we      = ex_flag_we & {2{acc}};
    end

    ex_flag_reg #(
        .FLAG_RST(FLAG_RST)
    ) u_flags (
        .clk(clk),
        .rst(rst),
        .we (flag_we),
        .d  (flag_d),
        .q  (flag_q)
    );

    assign p_Z        = flag_q[F_Z];
    assign p_CY       = flag_q[F_CY];
    assign ex_ready   = ex_ready_q;
    assign mem_valid  = (state_q != EMPTY);
    assign mem_result = head_q.result;
    assign mem_rd     = head_q.rd;
    assign mem_rf_we  = head_q.rf_we;
    assign fwd_valid  = mem_valid & head_q.rf_we;
    assign fwd_rd     = head_q.rd;
    assign fwd_result = head_q.result;

endmodule
